ly_oneshot_ctrl: RTL and testbench
==================================

LY_ONESHOT_CTRL -- requirements
Module: ly_oneshot_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 224, meaning the hit-vector width (matches the oneshot array).
REQ-002 SHALL have parameter PERSIST_INIT, default 4'd6, meaning the os_persist value after reset.
REQ-003 SHALL have parameter DRAIN_MAX, default 15, meaning the maximum number of DRAIN-state cycles before timeout.
REQ-004 SHALL have port clock, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port run_en, input, 1 bit: enables the hit path.
REQ-007 SHALL have port cfg_wr, input, 1 bit: one-cycle request to apply cfg_persist.
REQ-008 SHALL have port cfg_persist, input, 4 bits: requested persistence.
REQ-009 SHALL have port cfg_busy, output, 1 bit: a reconfiguration sequence is in progress.
REQ-010 SHALL have port cfg_done, output, 1 bit: one-cycle pulse when the new persistence is applied.
REQ-011 SHALL have port cfg_ovr, output, 1 bit: sticky flag set when cfg_wr arrives while busy.
REQ-012 SHALL have port drain_err, output, 1 bit: sticky flag set on DRAIN timeout.
REQ-013 SHALL have port hits_in, input, WIDTH bits: raw layer hits.
REQ-014 SHALL have port hits_out, output, WIDTH bits: gated hits to the oneshot array.
REQ-015 SHALL have port os_persist, output, 4 bits: persistence driven to the oneshot array.
REQ-016 SHALL have port os_reset, output, 1 bit: registered clear to the oneshot array.
REQ-017 SHALL have port os_any, input, 1 bit: OR of all oneshot outputs.
REQ-018 SHALL have port cnt_clr, input, 1 bit: clears blk_cnt, cfg_ovr and drain_err.
REQ-019 SHALL have port blk_cnt, output, 16 bits: count of cycles in which hits were blocked.

Function
REQ-020 SHALL implement FSM states RUN, GATE, FLUSH, DRAIN and LOAD.
REQ-021 SHALL transition from RUN to GATE when cfg_wr=1, capturing cfg_persist into a pending register on that edge.
REQ-022 SHALL transition GATE->FLUSH->DRAIN unconditionally, one cycle in each state.
REQ-023 SHALL, in DRAIN, go to LOAD when os_any=0; otherwise increment drain_cnt (4 bits, cleared on DRAIN entry).
REQ-024 SHALL, in DRAIN when drain_cnt reaches DRAIN_MAX with os_any=1, set drain_err and go to LOAD.
REQ-025 SHALL, in LOAD, register os_persist <= pending, set cfg_done for exactly the next cycle, and return to RUN.
REQ-026 SHALL drive hits_out = hits_in when state=RUN and run_en=1; otherwise hits_out = all zeros (combinational).
REQ-027 SHALL drive os_reset high exactly during the FLUSH cycle (registered, glitch-free).
REQ-028 SHALL drive cfg_busy high in states GATE, FLUSH, DRAIN and LOAD, and low in RUN.
REQ-029 SHALL, in minimum latency (os_any=0), sequence as: cfg_wr at cycle 0, GATE at 1, FLUSH at 2, DRAIN at 3, LOAD at 4, RUN with cfg_done=1 and the new os_persist visible at cycle 5.
REQ-030 SHALL ignore cfg_wr while cfg_busy=1 (pending unchanged) and set cfg_ovr.
REQ-031 SHALL accept cfg_wr in the cycle cfg_done is high, since the state is RUN.
REQ-032 SHALL run the full sequence even if cfg_persist equals os_persist; value 0 is legal.
REQ-033 SHALL increment blk_cnt when |hits_in=1 and hits_out is forced to zero (not RUN, or run_en=0).
REQ-034 SHALL saturate blk_cnt at 16'hFFFF.
REQ-035 SHALL give cnt_clr priority over increment and over same-cycle flag setting.

Reset
REQ-036 SHALL, on reset, set state=RUN, os_persist=PERSIST_INIT, os_reset=1 (for the reset cycle(s)), cfg_busy=0, cfg_done=0, cfg_ovr=0, drain_err=0, blk_cnt=0, pending=PERSIST_INIT and drain_cnt=0.
REQ-037 SHALL, on reset mid-sequence, abort the sequence, discard pending and not pulse cfg_done.
REQ-038 SHALL give reset priority over cfg_wr and cnt_clr.

Verification
REQ-039 SHALL verify: reset, then cfg_wr with cfg_persist=9 and os_any=0 -> cfg_busy high at cycles 1-4, os_reset high only at cycle 2, cfg_done and os_persist=9 at cycle 5.
REQ-040 SHALL verify: os_any held 1 for 3 DRAIN cycles -> LOAD delayed 3 cycles and drain_err stays 0.
REQ-041 SHALL verify: os_any stuck at 1 -> drain_err=1 after DRAIN_MAX cycles, then LOAD and cfg_done.
REQ-042 SHALL verify: second cfg_wr (value 3) at cycle 2 -> ignored, cfg_ovr=1, final os_persist equals the first value.
REQ-043 SHALL verify: hits_in=all-ones with run_en=0 for 70000 cycles -> hits_out=0 and blk_cnt=16'hFFFF; cnt_clr -> 0 next cycle.
REQ-044 SHALL verify: reset asserted during DRAIN -> os_persist=PERSIST_INIT, no cfg_done, state RUN.

Source files
------------

// File: rtl/ly_oneshot_ctrl.sv
// ly_oneshot_ctrl: reconfiguration sequencer for a oneshot array.
// A persistence change gates the hit path, clears the array, waits for it
// to drain (bounded by a timeout), then loads the new persistence value.
// Hits that are blocked while gated or disabled are counted.
module ly_oneshot_ctrl #(
  parameter int         WIDTH        = 224,
  parameter logic [3:0] PERSIST_INIT = 4'd6,
  parameter int         DRAIN_MAX    = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_en,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_persist,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_ovr,
  output logic             drain_err,
  input  logic [WIDTH-1:0] hits_in,
  output logic [WIDTH-1:0] hits_out,
  output logic [3:0]       os_persist,
  output logic             os_reset,
  input  logic             os_any,
  input  logic             cnt_clr,
  output logic [15:0]      blk_cnt
);

  localparam logic [2:0] ST_RUN   = 3'd0;
  localparam logic [2:0] ST_GATE  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;

  // drain_cnt counts completed busy DRAIN cycles; the last allowed one is
  // DRAIN_MAX-1, so at most DRAIN_MAX cycles are spent in DRAIN.
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_MAX - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  os_persist_q, os_persist_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic        cfg_ovr_q, cfg_ovr_d;
  logic        drain_err_q, drain_err_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic        os_reset_q;
  logic        cfg_done_q;
  logic        hit_pass;
  logic        hit_blocked;
  logic        timeout;

  assign hit_pass    = (state_q == ST_RUN) && run_en;
  assign hit_blocked = (|hits_in) && !hit_pass;

  // Next-state logic for the sequencer, flags and blocked-hit counter.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    pending_d    = pending_q;
    os_persist_d = os_persist_q;
    drain_cnt_d  = drain_cnt_q;
    cfg_ovr_d    = cfg_ovr_q;
    drain_err_d  = drain_err_q;
    blk_cnt_d    = blk_cnt_q;
    timeout      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (cfg_wr) begin
          state_d   = ST_GATE;
          pending_d = cfg_persist;
        end
      end
      ST_GATE:  state_d = ST_FLUSH;
      ST_FLUSH: begin
        state_d     = ST_DRAIN;
        drain_cnt_d = 4'd0;
      end
      ST_DRAIN: begin
        if (!os_any) begin
          state_d = ST_LOAD;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          timeout = 1'b1;
          state_d = ST_LOAD;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      ST_LOAD: begin
        os_persist_d = pending_q;
        state_d      = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // A write while busy is dropped; only the sticky flag records it.
    if (cfg_wr && (state_q != ST_RUN)) cfg_ovr_d = 1'b1;
    if (timeout) drain_err_d = 1'b1;
    if (hit_blocked && (blk_cnt_q != 16'hFFFF)) blk_cnt_d = blk_cnt_q + 16'd1;

    // Clearing wins over any same-cycle set or increment.
    if (cnt_clr) begin
      cfg_ovr_d   = 1'b0;
      drain_err_d = 1'b0;
      blk_cnt_d   = 16'd0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= ST_RUN;
      pending_q    <= PERSIST_INIT;
      os_persist_q <= PERSIST_INIT;
      drain_cnt_q  <= 4'd0;
      cfg_ovr_q    <= 1'b0;
      drain_err_q  <= 1'b0;
      blk_cnt_q    <= 16'd0;
      os_reset_q   <= 1'b1;
      cfg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      os_persist_q <= os_persist_d;
      drain_cnt_q  <= drain_cnt_d;
      cfg_ovr_q    <= cfg_ovr_d;
      drain_err_q  <= drain_err_d;
      blk_cnt_q    <= blk_cnt_d;
      os_reset_q   <= (state_d == ST_FLUSH);
      cfg_done_q   <= (state_q == ST_LOAD);
    end
  end

  assign hits_out   = hit_pass ? hits_in : '0;
  assign cfg_busy   = (state_q != ST_RUN);
  assign cfg_done   = cfg_done_q;
  assign cfg_ovr    = cfg_ovr_q;
  assign drain_err  = drain_err_q;
  assign os_persist = os_persist_q;
  assign os_reset   = os_reset_q;
  assign blk_cnt    = blk_cnt_q;

endmodule

// File: tb/tb_ly_oneshot_ctrl.sv
// Testbench for ly_oneshot_ctrl: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_ly_oneshot_ctrl;

  localparam int         W     = 224;
  localparam logic [3:0] PINIT = 4'd6;
  localparam int         DMAX  = 15;

  logic         clock = 1'b0;
  logic         reset;
  logic         run_en;
  logic         cfg_wr;
  logic [3:0]   cfg_persist;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_ovr;
  logic         drain_err;
  logic [W-1:0] hits_in;
  logic [W-1:0] hits_out;
  logic [3:0]   os_persist;
  logic         os_reset;
  logic         os_any;
  logic         cnt_clr;
  logic [15:0]  blk_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  ly_oneshot_ctrl #(.WIDTH(W), .PERSIST_INIT(PINIT), .DRAIN_MAX(DMAX)) dut (
    .clock(clock), .reset(reset), .run_en(run_en), .cfg_wr(cfg_wr),
    .cfg_persist(cfg_persist), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_ovr(cfg_ovr), .drain_err(drain_err), .hits_in(hits_in),
    .hits_out(hits_out), .os_persist(os_persist), .os_reset(os_reset),
    .os_any(os_any), .cnt_clr(cnt_clr), .blk_cnt(blk_cnt)
  );

  // Advance to just after the next rising edge (input drive point).
  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run_en = 1'b0; cfg_wr = 1'b0; cfg_persist = 4'd0;
    hits_in = '0; os_any = 1'b0; cnt_clr = 1'b0;
    drive_edge();
    drive_edge();
    @(negedge clock);
    vecs++; if (os_reset !== 1'b1) begin errs++; $display("FAIL reset.os_reset got %b exp 1", os_reset); end
    vecs++; if (cfg_busy !== 1'b0) begin errs++; $display("FAIL reset.busy got %b exp 0", cfg_busy); end
    vecs++; if (cfg_done !== 1'b0) begin errs++; $display("FAIL reset.done got %b exp 0", cfg_done); end
    vecs++; if (cfg_ovr !== 1'b0) begin errs++; $display("FAIL reset.ovr got %b exp 0", cfg_ovr); end
    vecs++; if (drain_err !== 1'b0) begin errs++; $display("FAIL reset.err got %b exp 0", drain_err); end
    vecs++; if (blk_cnt !== 16'd0) begin errs++; $display("FAIL reset.blk got %h exp 0", blk_cnt); end
    vecs++; if (os_persist !== PINIT) begin errs++; $display("FAIL reset.persist got %0d exp %0d", os_persist, PINIT); end
    drive_edge();
    reset = 1'b0;
    @(negedge clock);
    vecs++; if (os_reset !== 1'b1) begin errs++; $display("FAIL reset.os_reset_last got %b exp 1", os_reset); end
    drive_edge();
    @(negedge clock);
    vecs++; if (os_reset !== 1'b0) begin errs++; $display("FAIL reset.os_reset_rel got %b exp 0", os_reset); end
    drive_edge();
  endtask

  task automatic test_min_latency();
    logic [W-1:0] pat;
    logic         eb;
    pat = {7{32'hDEADBEEF}};
    run_en = 1'b1; hits_in = pat; os_any = 1'b0; cfg_persist = 4'd9;
    for (int c = 0; c <= 5; c++) begin
      cfg_wr = (c == 0);
      @(negedge clock);
      eb = (c >= 1 && c <= 4);
      vecs++; if (cfg_busy !== eb) begin errs++; $display("FAIL minlat.busy c%0d got %b exp %b", c, cfg_busy, eb); end
      vecs++; if (os_reset !== (c == 2)) begin errs++; $display("FAIL minlat.os_reset c%0d got %b exp %b", c, os_reset, c == 2); end
      vecs++; if (cfg_done !== (c == 5)) begin errs++; $display("FAIL minlat.done c%0d got %b exp %b", c, cfg_done, c == 5); end
      vecs++; if (os_persist !== ((c == 5) ? 4'd9 : PINIT)) begin errs++; $display("FAIL minlat.persist c%0d got %0d", c, os_persist); end
      vecs++; if (hits_out !== (eb ? '0 : pat)) begin errs++; $display("FAIL minlat.hits c%0d got %h", c, hits_out); end
      drive_edge();
    end
    cfg_wr = 1'b0; hits_in = '0;
  endtask

  task automatic test_drain_hold();
    cfg_persist = 4'd5;
    for (int c = 0; c <= 8; c++) begin
      cfg_wr = (c == 0);
      os_any = (c >= 3 && c <= 5);
      @(negedge clock);
      vecs++; if (cfg_busy !== (c >= 1 && c <= 7)) begin errs++; $display("FAIL hold.busy c%0d got %b", c, cfg_busy); end
      vecs++; if (cfg_done !== (c == 8)) begin errs++; $display("FAIL hold.done c%0d got %b", c, cfg_done); end
      vecs++; if (os_persist !== ((c == 8) ? 4'd5 : 4'd9)) begin errs++; $display("FAIL hold.persist c%0d got %0d", c, os_persist); end
      vecs++; if (drain_err !== 1'b0) begin errs++; $display("FAIL hold.err c%0d got %b exp 0", c, drain_err); end
      drive_edge();
    end
    cfg_wr = 1'b0; os_any = 1'b0;
  endtask

  task automatic test_drain_timeout();
    cfg_persist = 4'd2;
    os_any = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      cfg_wr = (c == 0);
      @(negedge clock);
      vecs++; if (cfg_busy !== (c >= 1 && c <= 18)) begin errs++; $display("FAIL tmo.busy c%0d got %b", c, cfg_busy); end
      vecs++; if (drain_err !== (c >= 18)) begin errs++; $display("FAIL tmo.err c%0d got %b exp %b", c, drain_err, c >= 18); end
      vecs++; if (cfg_done !== (c == 19)) begin errs++; $display("FAIL tmo.done c%0d got %b", c, cfg_done); end
      vecs++; if (os_persist !== ((c == 19) ? 4'd2 : 4'd5)) begin errs++; $display("FAIL tmo.persist c%0d got %0d", c, os_persist); end
      drive_edge();
    end
    cfg_wr = 1'b0; os_any = 1'b0;
    cnt_clr = 1'b1;
    drive_edge();
    cnt_clr = 1'b0;
    @(negedge clock);
    vecs++; if (drain_err !== 1'b0) begin errs++; $display("FAIL tmo.clr_err got %b exp 0", drain_err); end
    vecs++; if (blk_cnt !== 16'd0) begin errs++; $display("FAIL tmo.clr_blk got %h exp 0", blk_cnt); end
    drive_edge();
  endtask

  task automatic test_override();
    logic [3:0] ep;
    for (int c = 0; c <= 10; c++) begin
      cfg_wr      = (c == 0 || c == 2 || c == 5);
      cfg_persist = (c == 0) ? 4'd7 : (c == 2) ? 4'd3 : 4'd11;
      @(negedge clock);
      ep = (c < 5) ? 4'd2 : (c < 10) ? 4'd7 : 4'd11;
      vecs++; if (cfg_busy !== ((c >= 1 && c <= 4) || (c >= 6 && c <= 9))) begin errs++; $display("FAIL ovr.busy c%0d got %b", c, cfg_busy); end
      vecs++; if (cfg_done !== (c == 5 || c == 10)) begin errs++; $display("FAIL ovr.done c%0d got %b", c, cfg_done); end
      vecs++; if (os_persist !== ep) begin errs++; $display("FAIL ovr.persist c%0d got %0d exp %0d", c, os_persist, ep); end
      vecs++; if (cfg_ovr !== (c >= 3)) begin errs++; $display("FAIL ovr.flag c%0d got %b exp %b", c, cfg_ovr, c >= 3); end
      drive_edge();
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_clear_priority();
    logic eo;
    cfg_persist = 4'd4;
    for (int c = 0; c <= 5; c++) begin
      cfg_wr  = (c == 0 || c == 1 || c == 3);
      cnt_clr = (c == 1);
      @(negedge clock);
      eo = !(c == 2 || c == 3);
      vecs++; if (cfg_ovr !== eo) begin errs++; $display("FAIL clrpri.ovr c%0d got %b exp %b", c, cfg_ovr, eo); end
      vecs++; if (cfg_done !== (c == 5)) begin errs++; $display("FAIL clrpri.done c%0d got %b", c, cfg_done); end
      drive_edge();
    end
    cfg_wr = 1'b0; cnt_clr = 1'b0;
    @(negedge clock);
    vecs++; if (os_persist !== 4'd4) begin errs++; $display("FAIL clrpri.persist got %0d exp 4", os_persist); end
    drive_edge();
  endtask

  task automatic test_blocked();
    hits_in = '1; run_en = 1'b0; cnt_clr = 1'b1;
    drive_edge();
    cnt_clr = 1'b0;
    @(negedge clock);
    vecs++; if (blk_cnt !== 16'd0) begin errs++; $display("FAIL blk.start got %h exp 0", blk_cnt); end
    for (int n = 1; n <= 70000; n++) begin
      drive_edge();
      if (n == 1000 || n == 65535 || n == 70000) begin
        @(negedge clock);
        vecs++; if (blk_cnt !== ((n < 65535) ? 16'(n) : 16'hFFFF)) begin errs++; $display("FAIL blk.count n%0d got %h", n, blk_cnt); end
        vecs++; if (hits_out !== '0) begin errs++; $display("FAIL blk.hits n%0d got %h exp 0", n, hits_out); end
      end
    end
    drive_edge();
    cnt_clr = 1'b1;
    @(negedge clock);
    vecs++; if (blk_cnt !== 16'hFFFF) begin errs++; $display("FAIL blk.sat got %h exp ffff", blk_cnt); end
    drive_edge();
    cnt_clr = 1'b0;
    @(negedge clock);
    vecs++; if (blk_cnt !== 16'd0) begin errs++; $display("FAIL blk.clr got %h exp 0", blk_cnt); end
    drive_edge();
    @(negedge clock);
    vecs++; if (blk_cnt !== 16'd1) begin errs++; $display("FAIL blk.restart got %h exp 1", blk_cnt); end
    drive_edge();
    hits_in = '0;
  endtask

  task automatic test_reset_mid();
    cfg_persist = 4'd13; os_any = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      cfg_wr = (c == 0 || c == 4);
      reset  = (c == 4);
      @(negedge clock);
      if (c >= 1 && c <= 4) begin
        vecs++; if (cfg_busy !== 1'b1) begin errs++; $display("FAIL rstmid.busy_pre c%0d got %b exp 1", c, cfg_busy); end
      end
      if (c >= 5) begin
        vecs++; if (cfg_busy !== 1'b0) begin errs++; $display("FAIL rstmid.busy c%0d got %b exp 0", c, cfg_busy); end
        vecs++; if (cfg_done !== 1'b0) begin errs++; $display("FAIL rstmid.done c%0d got %b exp 0", c, cfg_done); end
        vecs++; if (os_persist !== PINIT) begin errs++; $display("FAIL rstmid.persist c%0d got %0d exp %0d", c, os_persist, PINIT); end
        vecs++; if (os_reset !== (c == 5)) begin errs++; $display("FAIL rstmid.os_reset c%0d got %b", c, os_reset); end
        vecs++; if (blk_cnt !== 16'd0) begin errs++; $display("FAIL rstmid.blk c%0d got %h exp 0", c, blk_cnt); end
      end
      drive_edge();
    end
    cfg_wr = 1'b0; reset = 1'b0; os_any = 1'b0;
  endtask

  // Randomized run against a transaction-level model: a sequence is tracked
  // by its age since acceptance, the number of busy drain cycles seen, and
  // whether the load step is due.
  task automatic test_random();
    int          age;
    int          drain_seen;
    bit          loading;
    bit          m_done;
    bit          m_ovr;
    bit          m_err;
    bit          rst_last;
    int          m_blk;
    logic [3:0]  m_pers;
    logic [3:0]  m_pend;
    bit          busy_now;
    bit          blocked;
    logic [W-1:0] eh;

    reset = 1'b1; cfg_wr = 1'b0; cnt_clr = 1'b0;
    drive_edge();
    reset = 1'b0;
    age = 0; drain_seen = 0; loading = 0; m_done = 0; m_ovr = 0; m_err = 0;
    rst_last = 1; m_blk = 0; m_pers = PINIT; m_pend = PINIT;

    for (int c = 0; c < 3000; c++) begin
      run_en      = ($urandom_range(0, 9) < 8);
      cfg_wr      = ($urandom_range(0, 9) < 2);
      cfg_persist = 4'($urandom);
      os_any      = ($urandom_range(0, 9) < 8);
      cnt_clr     = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < 7; k++) hits_in[k*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) hits_in = '0;

      @(negedge clock);
      busy_now = (age != 0);
      eh = (!busy_now && run_en) ? hits_in : '0;
      vecs++; if (cfg_busy !== busy_now) begin errs++; $display("FAIL rnd.busy c%0d got %b exp %b", c, cfg_busy, busy_now); end
      vecs++; if (os_reset !== ((age == 2) || rst_last)) begin errs++; $display("FAIL rnd.os_reset c%0d got %b", c, os_reset); end
      vecs++; if (cfg_done !== m_done) begin errs++; $display("FAIL rnd.done c%0d got %b exp %b", c, cfg_done, m_done); end
      vecs++; if (os_persist !== m_pers) begin errs++; $display("FAIL rnd.persist c%0d got %0d exp %0d", c, os_persist, m_pers); end
      vecs++; if (cfg_ovr !== m_ovr) begin errs++; $display("FAIL rnd.ovr c%0d got %b exp %b", c, cfg_ovr, m_ovr); end
      vecs++; if (drain_err !== m_err) begin errs++; $display("FAIL rnd.err c%0d got %b exp %b", c, drain_err, m_err); end
      vecs++; if (blk_cnt !== 16'(m_blk)) begin errs++; $display("FAIL rnd.blk c%0d got %0d exp %0d", c, blk_cnt, m_blk); end
      vecs++; if (hits_out !== eh) begin errs++; $display("FAIL rnd.hits c%0d got %h exp %h", c, hits_out, eh); end

      @(posedge clock);
      blocked  = (|hits_in) && !(!busy_now && run_en);
      rst_last = 0;
      m_done   = 0;
      if (!busy_now) begin
        if (cfg_wr) begin m_pend = cfg_persist; age = 1; end
      end else if (loading) begin
        m_pers = m_pend; m_done = 1; age = 0; loading = 0;
      end else if (age >= 3) begin
        if (!os_any) loading = 1;
        else begin
          drain_seen++;
          if (drain_seen == DMAX) begin m_err = 1; loading = 1; end
        end
        age++;
      end else begin
        age++;
        if (age == 3) drain_seen = 0;
      end
      if (cfg_wr && busy_now) m_ovr = 1;
      if (blocked && m_blk < 65535) m_blk++;
      if (cnt_clr) begin m_blk = 0; m_ovr = 0; m_err = 0; end
      #1;
    end
    cfg_wr = 1'b0; cnt_clr = 1'b0; os_any = 1'b0; hits_in = '0;
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_drain_hold();
    test_drain_timeout();
    test_override();
    test_clear_priority();
    test_blocked();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
